// File: rtl/scorecard_manager.sv
// scorecard_manager: one player's Yacht scorecard; sweeps the calculator via cat_sel to find the best unused category, records commits, tracks upper sum, bonus, total and game over.
// Ports: commands new_game/scan_start/commit(+commit_cat); calculator link cat_sel -> calc_score;
// status busy, scan_done/best_cat/best_score, commit_ok/commit_err, used_mask, upper_sum, bonus, total, game_over.
module scorecard_manager #(
  parameter int NUM_CAT      = 12,
  parameter int BONUS_THRESH = 63,
  parameter int BONUS_PTS    = 35
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic               scan_start,
  input  logic               commit,
  input  logic [3:0]         commit_cat,
  output logic [3:0]         cat_sel,
  input  logic [7:0]         calc_score,
  output logic               busy,
  output logic               scan_done,
  output logic [3:0]         best_cat,
  output logic [7:0]         best_score,
  output logic               commit_ok,
  output logic               commit_err,
  output logic [NUM_CAT-1:0] used_mask,
  output logic [6:0]         upper_sum,
  output logic               bonus,
  output logic [8:0]         total,
  output logic               game_over
);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state_q, state_d;
  logic [3:0] cat_q, run_cat_q, best_cat_q;
  logic [7:0] run_score_q, best_score_q;
  logic found_q, scan_done_q, commit_ok_q, commit_err_q, bonus_q, game_over_q;
  logic [NUM_CAT-1:0] used_q, used_nx;
  logic [6:0] upper_q;
  logic [8:0] total_q, upper_nx, total_nx;
  logic [15:0] used_x;
  logic idle, commit_valid, commit_go, commit_rej, scan_go, take, last, is_upper, bonus_nx;
  // widened copy so any 4-bit category index stays in range
  assign used_x       = 16'(used_q);
  assign idle         = state_q == IDLE;
  assign commit_valid = commit_cat < 4'(NUM_CAT) && !used_x[commit_cat];
  assign commit_go    = idle && !new_game && commit && commit_valid;
  assign commit_rej   = idle && !new_game && commit && !commit_valid;
  assign scan_go      = idle && !new_game && !commit && scan_start && !game_over_q;
  // strict > keeps the lowest index on ties
  assign take         = !used_x[cat_q] && (!found_q || calc_score > run_score_q);
  assign last         = cat_q == 4'(NUM_CAT - 1);
  assign is_upper     = cat_q < 4'd6;
  assign upper_nx     = 9'(upper_q) + (is_upper ? 9'(calc_score) : 9'd0);
  assign bonus_nx     = upper_nx >= 9'(BONUS_THRESH);
  // bonus points land only on the commit that first crosses the threshold
  assign total_nx     = total_q + 9'(calc_score) + (bonus_nx && !bonus_q ? 9'(BONUS_PTS) : 9'd0);
  assign used_nx      = used_q | (NUM_CAT'(1) << cat_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = new_game ? IDLE :
              commit_go ? COMMIT :
              scan_go ? SCAN :
              (state_q == SCAN && !last) ? SCAN : IDLE;
  end
  always_comb begin
    busy = !idle;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cat_q        <= '0;
      run_cat_q    <= '0;
      run_score_q  <= '0;
      found_q      <= 1'b0;
      best_cat_q   <= '0;
      best_score_q <= '0;
      scan_done_q  <= 1'b0;
      commit_ok_q  <= 1'b0;
      commit_err_q <= 1'b0;
      used_q       <= '0;
      upper_q      <= '0;
      bonus_q      <= 1'b0;
      total_q      <= '0;
      game_over_q  <= 1'b0;
    end else begin
      scan_done_q  <= 1'b0;
      commit_ok_q  <= 1'b0;
      commit_err_q <= 1'b0;
      if (new_game) begin
        cat_q        <= '0;
        found_q      <= 1'b0;
        best_cat_q   <= '0;
        best_score_q <= '0;
        used_q       <= '0;
        upper_q      <= '0;
        bonus_q      <= 1'b0;
        total_q      <= '0;
        game_over_q  <= 1'b0;
      end else begin
        if (commit_rej) commit_err_q <= 1'b1;
        if (commit_go) cat_q <= commit_cat;
        if (scan_go) begin
          cat_q   <= '0;
          found_q <= 1'b0;
        end
        if (state_q == SCAN) begin
          if (take) begin
            run_cat_q   <= cat_q;
            run_score_q <= calc_score;
            found_q     <= 1'b1;
          end
          cat_q <= last ? 4'd0 : cat_q + 4'd1;
          if (last) begin
            best_cat_q   <= take ? cat_q : run_cat_q;
            best_score_q <= take ? calc_score : run_score_q;
            scan_done_q  <= 1'b1;
          end
        end
        if (state_q == COMMIT) begin
          used_q      <= used_nx;
          upper_q     <= upper_nx[6:0];
          bonus_q     <= bonus_q | bonus_nx;
          total_q     <= total_nx;
          game_over_q <= &used_nx;
          commit_ok_q <= 1'b1;
          cat_q       <= '0;
        end
      end
    end
  assign cat_sel    = cat_q;
  assign scan_done  = scan_done_q;
  assign best_cat   = best_cat_q;
  assign best_score = best_score_q;
  assign commit_ok  = commit_ok_q;
  assign commit_err = commit_err_q;
  assign used_mask  = used_q;
  assign upper_sum  = upper_q;
  assign bonus      = bonus_q;
  assign total      = total_q;
  assign game_over  = game_over_q;
endmodule

// File: tb/tb_scorecard_manager.sv
// tb_scorecard_manager: directed self-checking bench for scorecard_manager.
module tb_scorecard_manager;
  logic clk = 0, rst = 1, new_game = 0, scan_start = 0, commit = 0;
  logic [3:0] commit_cat = 0;
  logic [3:0] cat_sel, best_cat;
  logic [7:0] calc_score, best_score;
  logic busy, scan_done, commit_ok, commit_err, bonus, game_over;
  logic [11:0] used_mask;
  logic [6:0] upper_sum;
  logic [8:0] total;
  logic [7:0] scores [16];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  always_comb calc_score = scores[cat_sel];
  scorecard_manager dut (
    .clk(clk), .rst(rst), .new_game(new_game), .scan_start(scan_start),
    .commit(commit), .commit_cat(commit_cat), .cat_sel(cat_sel), .calc_score(calc_score),
    .busy(busy), .scan_done(scan_done), .best_cat(best_cat), .best_score(best_score),
    .commit_ok(commit_ok), .commit_err(commit_err), .used_mask(used_mask),
    .upper_sum(upper_sum), .bonus(bonus), .total(total), .game_over(game_over)
  );
  task tick;
    @(posedge clk);
    #1;
  endtask
  task pulse_new_game;
    new_game = 1;
    tick;
    new_game = 0;
  endtask
  task do_commit(input logic [3:0] c, output logic ok, output logic err);
    commit_cat = c;
    commit = 1;
    tick;
    commit = 0;
    err = commit_err;
    tick;
    ok = commit_ok;
  endtask
  task run_scan(output int busy_cnt, output int done_at);
    scan_start = 1;
    tick;
    scan_start = 0;
    busy_cnt = 0;
    done_at = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) tick;
      if (busy) busy_cnt++;
      if (scan_done && done_at == 0) done_at = i;
    end
  endtask
  task test_reset;
    logic [66:0] all;
    rst = 1;
    tick;
    tick;
    all = {cat_sel, busy, scan_done, best_cat, best_score, commit_ok, commit_err,
           used_mask, upper_sum, bonus, total, game_over, 13'd0};
    vectors++;
    if (all !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", all);
    end
    rst = 0;
    tick;
  endtask
  task test_scan_commit;
    int bc, da;
    logic ok, err;
    scores = '{8'd0, 8'd4, 8'd9, 8'd0, 8'd0, 8'd0, 8'd13, 8'd0, 8'd25, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_scan(bc, da);
    vectors++;
    if (da !== 13) begin miscompares++; $display("FAIL scan_done_latency: got %0d expected 13", da); end
    vectors++;
    if (bc !== 12) begin miscompares++; $display("FAIL scan_busy_cycles: got %0d expected 12", bc); end
    vectors++;
    if ({best_cat, best_score} !== {4'd8, 8'd25}) begin
      miscompares++; $display("FAIL scan_best: got cat %0d score %0d expected cat 8 score 25", best_cat, best_score);
    end
    do_commit(4'd8, ok, err);
    vectors++;
    if ({ok, err, total, used_mask} !== {1'b1, 1'b0, 9'd25, 12'h100}) begin
      miscompares++;
      $display("FAIL commit_fh: got ok %b err %b total %0d used %h expected ok 1 err 0 total 25 used 100", ok, err, total, used_mask);
    end
  endtask
  task test_reject;
    logic ok, err;
    do_commit(4'd8, ok, err);
    vectors++;
    if ({ok, err, total} !== {1'b0, 1'b1, 9'd25}) begin
      miscompares++; $display("FAIL reject_used: got ok %b err %b total %0d expected ok 0 err 1 total 25", ok, err, total);
    end
    do_commit(4'd12, ok, err);
    vectors++;
    if ({ok, err, total, used_mask} !== {1'b0, 1'b1, 9'd25, 12'h100}) begin
      miscompares++;
      $display("FAIL reject_range: got ok %b err %b total %0d used %h expected ok 0 err 1 total 25 used 100", ok, err, total, used_mask);
    end
  endtask
  task test_bonus;
    logic ok, err;
    pulse_new_game;
    vectors++;
    if ({used_mask, total, best_cat, best_score} !== 33'd0) begin
      miscompares++; $display("FAIL new_game_clear: got used %h total %0d best %0d/%0d expected zeros", used_mask, total, best_cat, best_score);
    end
    scores = '{8'd3, 8'd0, 8'd0, 8'd16, 8'd25, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_commit(4'd5, ok, err);
    do_commit(4'd4, ok, err);
    vectors++;
    if ({upper_sum, bonus, total} !== {7'd55, 1'b0, 9'd55}) begin
      miscompares++; $display("FAIL pre_bonus: got upper %0d bonus %b total %0d expected 55 0 55", upper_sum, bonus, total);
    end
    do_commit(4'd3, ok, err);
    vectors++;
    if ({ok, upper_sum, bonus, total} !== {1'b1, 7'd71, 1'b1, 9'd106}) begin
      miscompares++; $display("FAIL bonus_cross: got ok %b upper %0d bonus %b total %0d expected 1 71 1 106", ok, upper_sum, bonus, total);
    end
    do_commit(4'd0, ok, err);
    vectors++;
    if ({upper_sum, bonus, total} !== {7'd74, 1'b1, 9'd109}) begin
      miscompares++; $display("FAIL bonus_once: got upper %0d bonus %b total %0d expected 74 1 109", upper_sum, bonus, total);
    end
  endtask
  task test_tie;
    int bc, da;
    logic ok, err;
    pulse_new_game;
    scores = '{8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd10, 8'd25, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0};
    do_commit(4'd8, ok, err);
    do_commit(4'd11, ok, err);
    run_scan(bc, da);
    vectors++;
    if ({da, best_cat, best_score} !== {32'd13, 4'd1, 8'd10}) begin
      miscompares++; $display("FAIL scan_tie: got done %0d cat %0d score %0d expected 13 1 10", da, best_cat, best_score);
    end
  endtask
  task test_abort;
    logic [66:0] all;
    logic seen;
    scan_start = 1;
    tick;
    scan_start = 0;
    for (int i = 0; i < 4; i++) tick;
    #2 rst = 1;
    #1;
    all = {cat_sel, busy, scan_done, best_cat, best_score, commit_ok, commit_err,
           used_mask, upper_sum, bonus, total, game_over, 13'd0};
    vectors++;
    if (all !== 67'd0) begin
      miscompares++; $display("FAIL async_reset: got %h expected 0", all);
    end
    tick;
    rst = 0;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick;
      seen = seen | scan_done | busy;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL scan_after_reset: got 1 expected 0"); end
    scores[0] = 8'd5;
    commit_cat = 0;
    commit = 1;
    tick;
    commit = 0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL commit_busy: got %b expected 1", busy); end
    pulse_new_game;
    seen = commit_ok;
    tick;
    seen = seen | commit_ok;
    vectors++;
    if ({seen, busy, used_mask, total} !== 23'd0) begin
      miscompares++; $display("FAIL commit_abort: got ok %b busy %b used %h total %0d expected 0 0 0 0", seen, busy, used_mask, total);
    end
  endtask
  task test_game_over;
    int bc, da, bad;
    logic ok, err, go_early;
    pulse_new_game;
    scores = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd10, 8'd10, 8'd25, 8'd30, 8'd40, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0};
    commit_cat = 6;
    commit = 1;
    scan_start = 1;
    tick;
    commit = 0;
    scan_start = 0;
    vectors++;
    if ({busy, cat_sel} !== {1'b1, 4'd6}) begin
      miscompares++; $display("FAIL commit_over_scan: got busy %b cat_sel %0d expected 1 6", busy, cat_sel);
    end
    tick;
    vectors++;
    if ({commit_ok, total} !== {1'b1, 9'd10}) begin
      miscompares++; $display("FAIL commit_over_scan_ok: got ok %b total %0d expected 1 10", commit_ok, total);
    end
    bad = 0;
    go_early = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 6) continue;
      go_early = go_early | game_over;
      do_commit(4'(k), ok, err);
      if (!ok) bad++;
    end
    vectors++;
    if (bad !== 0 || go_early !== 1'b0) begin
      miscompares++; $display("FAIL fill_card: got %0d rejected early_go %b expected 0 0", bad, go_early);
    end
    vectors++;
    if ({game_over, used_mask, upper_sum, bonus, total} !== {1'b1, 12'hfff, 7'd21, 1'b0, 9'd186}) begin
      miscompares++;
      $display("FAIL game_over: got go %b used %h upper %0d bonus %b total %0d expected 1 fff 21 0 186", game_over, used_mask, upper_sum, bonus, total);
    end
    run_scan(bc, da);
    vectors++;
    if ({bc, da} !== 64'd0) begin
      miscompares++; $display("FAIL scan_when_over: got busy %0d done %0d expected 0 0", bc, da);
    end
  endtask
  initial begin
    scores = '{default: 8'd0};
    test_reset;
    test_scan_commit;
    test_reject;
    test_bonus;
    test_tie;
    test_abort;
    test_game_over;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/scorecard_manager.md
Name: scorecard_manager

Overview:
Sequential owner of one player's Yacht scorecard. It drives the category-select input of the combinational score calculator and consumes that calculator's 8-bit score.
- Scan mode sweeps all categories to find the best unused category for the current dice.
- Commit mode records one category's score into the card.
- It maintains the upper-section sum, the upper bonus, the grand total and the game-over flag.

Parameters:
NUM_CAT, 12, number of categories (0-5 upper, 6-11 lower; same encoding as the calculator).
BONUS_THRESH, 63, upper-sum threshold for the bonus.
BONUS_PTS, 35, bonus points added to total.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset: asynchronous, active-high.
new_game  in  1  1-cycle pulse; clears the scorecard.
scan_start  in  1  1-cycle pulse; start the best-category scan on the current dice.
commit  in  1  1-cycle pulse; record score for commit_cat.
commit_cat  in  4  category to record; sampled when commit=1.
cat_sel  out  4  category select driven to the score calculator.
calc_score  in  8  calculator score for cat_sel; combinational, valid the same cycle.
busy  out  1  high while in SCAN or COMMIT.
scan_done  out  1  1-cycle pulse when best_cat/best_score update.
best_cat  out  4  best unused category from the last scan.
best_score  out  8  score of best_cat.
commit_ok  out  1  1-cycle pulse; commit accepted.
commit_err  out  1  1-cycle pulse; commit rejected.
used_mask  out  12  bit k=1 once category k is recorded.
upper_sum  out  7  sum of recorded categories 0-5 (max 105).
bonus  out  1  high when upper_sum >= BONUS_THRESH.
total  out  9  all recorded scores + bonus*BONUS_PTS (max 345).
game_over  out  1  high when used_mask is all ones.

Behaviour:
- Reset (async, rst=1): every output register is 0 and the FSM enters IDLE. This covers cat_sel, busy, scan_done, best_cat, best_score, commit_ok, commit_err, used_mask, upper_sum, bonus, total and game_over.
- FSM states: IDLE, SCAN, COMMIT. cat_sel=0 in IDLE.
- Priority in any state: new_game > commit > scan_start.
  - new_game clears used_mask, sums, bonus, total, best_cat and best_score, and aborts any scan or commit.
  - On new_game, the FSM goes to IDLE next cycle with no done, ok or err pulse.
- commit and scan_start are ignored while busy=1.
- scan_start is ignored when game_over=1.
- If commit and scan_start arrive together in IDLE, the commit is taken and the scan request is dropped.
- SCAN sequence:
  - scan_start at edge N moves the FSM to SCAN with cat_sel=0 and busy=1 from cycle N+1.
  - cat_sel increments once per cycle through 0..11.
  - calc_score is sampled on each cycle's edge.
  - Only categories with used_mask[k]=0 are candidates.
  - A candidate replaces the running best if it is the first candidate or its score is strictly greater. Ties keep the lower index.
  - After sampling k=11, best_cat and best_score are registered, scan_done pulses and the FSM returns to IDLE.
  - scan_done is high 13 cycles after the scan_start edge; busy is high for 12 cycles.
  - best_cat and best_score hold until the next completed scan, new_game or reset.
- COMMIT sequence:
  - commit in IDLE is rejected if commit_cat >= NUM_CAT or used_mask[commit_cat]=1. On rejection, commit_err pulses the next cycle and no state changes.
  - Otherwise commit_cat is latched, the FSM enters COMMIT and cat_sel drives the latched value for one cycle (busy=1).
  - At the end of that cycle, calc_score is added to total. If the category is 0-5, it is also added to upper_sum. used_mask[cat] is set.
  - commit_ok pulses on the cycle after COMMIT, together with the updated used_mask, upper_sum and total. The FSM returns to IDLE.
- Bonus arithmetic:
  - Bonus is added exactly once, on the commit that first makes upper_sum >= BONUS_THRESH.
  - bonus goes high in the same cycle, and total includes BONUS_PTS from that cycle.
  - Adders are 9 bits wide; by the bounds above no overflow is possible.
- game_over is registered and rises with the commit_ok of the 12th commit.
- Dice stability: the dice source must hold the dice steady while busy=1. The block does not sample the dice.

Test Plan:
1. Fresh card, dice 3,3,3,2,2, scan_start → scan_done at +13 cycles, best_cat=8, best_score=25, busy high for 12 cycles. Then commit_cat=8 → commit_ok 2 cycles after commit, total=25, used_mask=12'h100.
2. Repeat commit_cat=8 → commit_err pulse, total stays 25. commit_cat=12 → commit_err, no state change.
3. Commit 6,6,6,6,6 to cat 5 (30), 5,5,5,5,5 to cat 4 (25), 4,4,4,4,1 to cat 3 (16) → upper_sum=71, bonus=1, total=106 on the third commit_ok.
4. Cats 8 and 11 used, dice 2,2,2,2,2, scan → best_cat=1, best_score=10 (tie with 6 and 7 resolved to the lowest index).
5. Assert rst during scan cycle 5 → all outputs 0 immediately, no scan_done. new_game during COMMIT → no commit_ok, used_mask=0.
6. Commit all 12 categories → game_over=1 with the 12th commit_ok. A later scan_start → busy stays 0, no scan_done.
